// File: rtl/cmd_capture.sv
// Operator push-button capture: two-flop sync, per-button debounce, and a one-hot
// command register with a pending flag that the core acknowledges.
module cmd_capture #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btnRaw,
  input  logic       clrCmd,
  input  logic       cmdAck,
  output logic [3:0] lastCmd,
  output logic       cmdStrobe,
  output logic       cmdValid,
  output logic       deci,
  output logic       cmdOverrun
);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       PEND     = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] s1_reg;
  logic [3:0] s2_reg;
  logic [3:0] rise;
  logic [3:0] sel;
  logic [0:0] state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 4'h0;
      s2_reg <= 4'h0;
    end else begin
      s1_reg <= btnRaw;
      s2_reg <= s1_reg;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_db
    logic [CNT_W-1:0] cnt_reg;
    logic             db_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
        db_reg  <= 1'b0;
      end else if (s2_reg[gi] == db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        db_reg  <= s2_reg[gi];
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    // Press fires on the same edge the debounced level rises.
    assign rise[gi] = s2_reg[gi] & ~db_reg & (cnt_reg == CNT_LAST);
  end

  // Isolate the lowest set bit: bit0 has highest priority, others are dropped.
  assign sel = rise & (~rise + 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      lastCmd    <= 4'h0;
      cmdStrobe  <= 1'b0;
      cmdOverrun <= 1'b0;
    end else begin
      cmdStrobe <= 1'b0;
      if (clrCmd) begin
        state_reg  <= IDLE;
        lastCmd    <= 4'h0;
        cmdOverrun <= 1'b0;
      end else if (sel != 4'h0) begin
        if (state_reg == PEND) begin
          cmdOverrun <= 1'b1;
        end
        state_reg <= PEND;
        lastCmd   <= sel;
        cmdStrobe <= 1'b1;
      end else if (cmdAck) begin
        state_reg <= IDLE;
      end
    end
  end

  assign cmdValid = (state_reg == PEND);
  assign deci     = cmdValid;

endmodule

// File: tb/tb_cmd_capture.sv
// Bench for cmd_capture: directed scenarios plus random button traffic, checked by a
// scoreboard fed from a window-based behavioural model.
module tb_cmd_capture;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btnRaw;
  logic       clrCmd;
  logic       cmdAck;
  logic [3:0] lastCmd;
  logic       cmdStrobe;
  logic       cmdValid;
  logic       deci;
  logic       cmdOverrun;

  cmd_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btnRaw(btnRaw), .clrCmd(clrCmd), .cmdAck(cmdAck),
    .lastCmd(lastCmd), .cmdStrobe(cmdStrobe), .cmdValid(cmdValid), .deci(deci),
    .cmdOverrun(cmdOverrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] last;
    logic       strobe;
    logic       valid;
    logic       ovr;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t       exp_q[$];
  logic [3:0] strobe_q[$];
  exp_t       mon_e;

  // Reference model: accepted level flips once the last D synchronised samples all disagree.
  logic [3:0] m_s1, m_s2, m_db, m_last;
  logic       m_pend, m_ovr, m_strobe;
  bit         hist[4][$];

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic model_edge(logic [3:0] raw, logic clr, logic ack, logic r);
    logic [3:0] smp;
    logic [3:0] rises;
    logic [3:0] pick;
    bit         all_diff;
    m_strobe = 1'b0;
    if (r) begin
      m_s1 = 4'h0; m_s2 = 4'h0; m_db = 4'h0;
      for (int b = 0; b < 4; b++) hist[b].delete();
      m_last = 4'h0; m_pend = 1'b0; m_ovr = 1'b0;
      return;
    end
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    rises = 4'h0;
    for (int b = 0; b < 4; b++) begin
      hist[b].push_back(smp[b]);
      if (hist[b].size() > D) void'(hist[b].pop_front());
      if (hist[b].size() == D) begin
        all_diff = 1'b1;
        for (int k = 0; k < hist[b].size(); k++)
          if (hist[b][k] == m_db[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_db[b]  = smp[b];
          rises[b] = smp[b];
          hist[b].delete();
        end
      end
    end
    pick = 4'h0;
    for (int b = 3; b >= 0; b--) if (rises[b]) pick = 4'(1 << b);
    if (clr) begin
      m_last = 4'h0; m_pend = 1'b0; m_ovr = 1'b0;
    end else if (pick != 4'h0) begin
      if (m_pend) m_ovr = 1'b1;
      m_pend = 1'b1; m_last = pick; m_strobe = 1'b1;
      strobe_q.push_back(pick);
    end else if (ack) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic step(logic [3:0] raw, logic clr, logic ack, logic r);
    exp_t e;
    btnRaw = raw; clrCmd = clr; cmdAck = ack; rst = r;
    model_edge(raw, clr, ack, r);
    @(posedge clk);
    e.last = m_last; e.strobe = m_strobe; e.valid = m_pend; e.ovr = m_ovr;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(logic [3:0] raw, int n, output int strobes);
    strobes = 0;
    repeat (n) begin
      step(raw, 1'b0, 1'b0, 1'b0);
      if (cmdStrobe === 1'b1) strobes++;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("outputs{last,strobe,valid,deci,ovr}",
            {lastCmd, cmdStrobe, cmdValid, deci, cmdOverrun},
            {mon_e.last, mon_e.strobe, mon_e.valid, mon_e.valid, mon_e.ovr});
    end
    if (cmdStrobe === 1'b1) begin
      if (strobe_q.size() == 0) check("strobe_unexpected_queue_size", strobe_q.size(), 1);
      else check("strobe_code", lastCmd, strobe_q.pop_front());
    end
  end

  initial begin
    int         ns;
    int         first;
    logic [3:0] raw;
    rst = 1'b1; btnRaw = 4'h0; clrCmd = 1'b0; cmdAck = 1'b0;
    @(posedge clk); #1;
    step(4'h0, 1'b0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0, 1'b1);
    check("reset_lastCmd", lastCmd, 4'h0);
    check("reset_flags", {cmdStrobe, cmdValid, deci, cmdOverrun}, 4'h0);

    // Single press latency.
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(4'h2, 1'b0, 1'b0, 1'b0);
      if (cmdStrobe === 1'b1 && first == 0) first = i;
    end
    check("t1_strobe_edge", first, 6);
    check("t1_lastCmd", lastCmd, 4'h2);
    check("t1_valid_deci_ovr", {cmdValid, deci, cmdOverrun}, 3'b110);

    // Short glitch on bit0 is ignored.
    run(4'h0, 8, ns);
    run(4'h1, 3, ns);
    run(4'h0, 8, ns);
    check("t2_no_strobe", ns, 0);
    check("t2_lastCmd", lastCmd, 4'h2);
    check("t2_valid", cmdValid, 1'b1);

    // Acknowledge, then new press.
    step(4'h0, 1'b0, 1'b1, 1'b0);
    check("t3_ack_valid", cmdValid, 1'b0);
    check("t3_ack_last", lastCmd, 4'h2);
    run(4'h8, 8, ns);
    check("t3_press_last", lastCmd, 4'h8);
    check("t3_press_valid", cmdValid, 1'b1);
    step(4'h8, 1'b0, 1'b1, 1'b0);
    run(4'h0, 8, ns);

    // Overrun.
    run(4'h1, 8, ns);
    run(4'h0, 8, ns);
    run(4'h4, 8, ns);
    check("t4_last", lastCmd, 4'h4);
    check("t4_ovr", cmdOverrun, 1'b1);
    step(4'h4, 1'b0, 1'b1, 1'b0);
    check("t4_ovr_after_ack", cmdOverrun, 1'b1);
    step(4'h4, 1'b1, 1'b0, 1'b0);
    check("t4_ovr_after_clr", cmdOverrun, 1'b0);
    check("t4_last_after_clr", lastCmd, 4'h0);
    run(4'h0, 8, ns);

    // Simultaneous presses.
    run(4'hA, 8, ns);
    check("t5_single_strobe", ns, 1);
    check("t5_last", lastCmd, 4'h2);
    run(4'h0, 8, ns);
    run(4'h8, 8, ns);
    check("t5_repress_last", lastCmd, 4'h8);
    run(4'h0, 8, ns);

    // Clear and ack on the registering edge.
    run(4'h1, 5, ns);
    step(4'h1, 1'b1, 1'b1, 1'b0);
    check("t6_clr_last", lastCmd, 4'h0);
    check("t6_clr_valid", cmdValid, 1'b0);
    check("t6_clr_strobe", cmdStrobe, 1'b0);
    run(4'h0, 8, ns);

    // Reset mid-count with button held.
    run(4'h4, 3, ns);
    step(4'h4, 1'b0, 1'b0, 1'b1);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(4'h4, 1'b0, 1'b0, 1'b0);
      if (cmdStrobe === 1'b1 && first == 0) first = i;
    end
    check("t6_rst_press_edge", first, 6);
    check("t6_rst_last", lastCmd, 4'h4);

    // Random traffic.
    raw = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) raw = 4'($urandom_range(0, 15));
      step(raw, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 299) == 0);
    end

    @(negedge clk); #1;
    check("strobe_queue_drained", strobe_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
